// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    typedef logic [7:0] byte_t;

    // Header byte base; the granted requester index is OR-ed into the low bits.
    localparam byte_t TAG_BASE = 8'hA0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals of the UART transmit arbiter
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]   i_req_valid;
    logic [N_REQ*8-1:0] i_req_data;
    logic [N_REQ-1:0]   i_req_last;
    logic [N_REQ-1:0]   o_req_ready;
    logic [7:0]         o_wr_data;
    logic               o_write;
    logic               i_full;
    logic [N_REQ-1:0]   o_grant;
    logic               o_busy;

    // Environment side: requesters plus the transmitter full flag.
    modport master (
        output i_req_valid,
        output i_req_data,
        output i_req_last,
        output i_full,
        input  o_req_ready,
        input  o_wr_data,
        input  o_write,
        input  o_grant,
        input  o_busy
    );

    // Arbiter side.
    modport slave (
        input  i_req_valid,
        input  i_req_data,
        input  i_req_last,
        input  i_full,
        output o_req_ready,
        output o_wr_data,
        output o_write,
        output o_grant,
        output o_busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker, search starts just above ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets from the far end down so the nearest requester above ptr wins last.
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = |req;
        c     = 0;
        for (int off = N; off >= 1; off--) begin
            c = (int'(ptr) + off) % N;
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter in front of a buffered UART transmitter (optional header: UART_ARB_TAG_EN)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);

    arb_state_t       state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [IW-1:0]    gidx, gidx_n;
    logic [N_REQ-1:0] grant, grant_n;
    logic [CW-1:0]    count, count_n;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic [N_REQ-1:0] ready;
    logic             write;
    byte_t            wdata;

    logic             g_valid;
    logic             g_last;
    byte_t            g_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (bus.i_req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign g_valid = bus.i_req_valid[gidx];
    assign g_last  = bus.i_req_last[gidx];
    assign g_data  = bus.i_req_data[int'(gidx)*8 +: 8];

    // Next-state and output decode; a byte moves only when the owner is valid and the FIFO has room.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gidx_n  = gidx;
        grant_n = grant;
        count_n = count;
        ready   = '0;
        write   = 1'b0;
        wdata   = '0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_grant;
                    gidx_n  = pick_idx;
                    count_n = '0;
`ifdef UART_ARB_TAG_EN
                    state_n = TAG;
`else
                    state_n = XFER;
`endif
                end
            end

`ifdef UART_ARB_TAG_EN
            TAG: begin
                if (!bus.i_full) begin
                    write   = 1'b1;
                    wdata   = TAG_BASE | byte_t'(gidx);
                    state_n = XFER;
                end
            end
`endif

            XFER: begin
                ready[gidx] = !bus.i_full;
                if (g_valid && !bus.i_full) begin
                    write = 1'b1;
                    wdata = g_data;
                    // Release on the last byte, or when this byte brings the count up to MAX_LEN.
                    if (g_last || (count == CW'(MAX_LEN - 1))) begin
                        state_n = IDLE;
                        ptr_n   = gidx;
                        grant_n = '0;
                        count_n = '0;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State register; reset drops any grant at once and re-arms requester 0 as first priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= IW'(N_REQ - 1);
            gidx  <= '0;
            grant <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gidx  <= gidx_n;
            grant <= grant_n;
            count <= count_n;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_write     = write;
    assign bus.o_wr_data   = wdata;
    assign bus.o_grant     = grant;
    assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (honours UART_ARB_TAG_EN)
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(
        .N_REQ   (N),
        .MAX_LEN (ML)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef logic [8:0] ent_t;   // {last, data}

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*8-1:0] data;
        logic [N-1:0]   last;
        logic           full;
        logic [N-1:0]   e_ready;
        logic           e_write;
        logic [7:0]     e_wdata;
        logic [N-1:0]   e_grant;
        logic           e_busy;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         mptr;
    ent_t       dq[N][$];
    logic [7:0] exp_q[$];
    logic [7:0] wr_log[$];
    vec_t       vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic [N-1:0] l, input logic f);
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_req_last  = l;
        bus.i_full      = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        mptr = N - 1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic [N-1:0] l,
                                input logic f, input logic [N-1:0] er, input logic ew, input logic [7:0] ed,
                                input logic [N-1:0] eg, input logic eb);
        vec_t r;
        r.valid = v; r.data = d; r.last = l; r.full = f;
        r.e_ready = er; r.e_write = ew; r.e_wdata = ed; r.e_grant = eg; r.e_busy = eb;
        return r;
    endfunction

    // Message-level model: round-robin over requesters with pending bytes, up to MAX_LEN bytes or last.
    task automatic build_expected();
        ent_t mq[N][$];
        int   g;
        int   n;
        bit   found;
        ent_t e;
        for (int k = 0; k < N; k++) mq[k] = dq[k];
        exp_q.delete();
        forever begin
            found = 1'b0;
            g     = 0;
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (mptr + off) % N;
                if (!found && mq[c].size() > 0) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (!found) break;
`ifdef UART_ARB_TAG_EN
            exp_q.push_back(8'hA0 | 8'(g));
`endif
            n = 0;
            forever begin
                e = mq[g].pop_front();
                exp_q.push_back(e[7:0]);
                n++;
                if (e[8] || n == ML || mq[g].size() == 0) break;
            end
            mptr = g;
        end
    endtask

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) if (dq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // full_mode: 0 never full, 1 full during cycles 3..7, 2 random full
    task automatic run(input int full_mode, input bit drop_en);
        int             cyc;
        logic [N-1:0]   v;
        logic [N*8-1:0] d;
        logic [N-1:0]   l;
        logic           f;
        logic [7:0]     e;
        cyc = 0;
        build_expected();
        wr_log.delete();
        while ((any_pending() || exp_q.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            v = '0; d = '0; l = '0;
            for (int k = 0; k < N; k++) begin
                if (dq[k].size() > 0) begin
                    v[k]         = !(drop_en && bus.o_grant[k] && ($urandom_range(3) == 0));
                    d[k*8 +: 8]  = dq[k][0][7:0];
                    l[k]         = dq[k][0][8];
                end
            end
            if (full_mode == 0)      f = 1'b0;
            else if (full_mode == 1) f = (cyc >= 3 && cyc <= 7);
            else                     f = ($urandom_range(9) < 3);
            drive(v, d, l, f);
            #1;
            if (f) begin
                chk("no_write_when_full", 32'(bus.o_write), 32'd0);
                chk("no_ready_when_full", 32'(bus.o_req_ready), 32'd0);
            end
            if (full_mode == 1 && cyc == 8) chk("write_when_full_drops", 32'(bus.o_write), 32'd1);
            if (bus.o_write) begin
                wr_log.push_back(bus.o_wr_data);
                if (exp_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_data", 32'(bus.o_wr_data), 32'(e));
                end
            end
            for (int k = 0; k < N; k++)
                if (v[k] && bus.o_req_ready[k]) void'(dq[k].pop_front());
            cyc++;
        end
        chk("run_complete", 32'(cyc < 2000), 32'd1);
        for (int k = 0; k < N; k++) dq[k].delete();
        exp_q.delete();
        @(negedge clk);
        drive('0, '0, '0, 1'b0);
        #1;
        chk("idle_busy", 32'(bus.o_busy), 32'd0);
        chk("idle_grant", 32'(bus.o_grant), 32'd0);
    endtask

    initial begin
        int cnt;
        int guard;
        int nm;
        int len;
        drive('0, '0, '0, 1'b0);

        // Single-cycle vectors for the basic message from requester 1 (or the tagged one from requester 2).
`ifdef UART_ARB_TAG_EN
        vt.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
        vt.push_back(mk(4'b0100, 32'h0055_0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
        vt.push_back(mk(4'b0100, 32'h0055_0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0100, 32'h0055_0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hA2, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0100, 32'h0055_0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h55, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
`else
        vt.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
        vt.push_back(mk(4'b0010, 32'h0000_1100, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
        vt.push_back(mk(4'b0010, 32'h0000_1100, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0010, 32'h0000_2200, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h22, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0010, 32'h0000_3300, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0010, 32'h0000_3300, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h33, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
`endif
        do_reset();
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].valid, vt[i].data, vt[i].last, vt[i].full);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus.o_req_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d_write", i), 32'(bus.o_write), 32'(vt[i].e_write));
            chk($sformatf("vec%0d_wdata", i), 32'(bus.o_wr_data), 32'(vt[i].e_wdata));
            chk($sformatf("vec%0d_grant", i), 32'(bus.o_grant), 32'(vt[i].e_grant));
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(vt[i].e_busy));
        end
        drive('0, '0, '0, 1'b0);

        // Requesters 0 and 2 contest after reset, then again with ptr parked on 0.
        do_reset();
        dq[0].push_back({1'b0, 8'h10}); dq[0].push_back({1'b1, 8'h11});
        dq[2].push_back({1'b0, 8'h20}); dq[2].push_back({1'b1, 8'h21});
        run(0, 1'b0);
`ifdef UART_ARB_TAG_EN
        chk("first_contest_owner", 32'(wr_log[0]), 32'hA0);
`else
        chk("first_contest_owner", 32'(wr_log[0]), 32'h10);
`endif
        dq[0].push_back({1'b1, 8'h12});
        run(0, 1'b0);
        dq[0].push_back({1'b0, 8'h13}); dq[0].push_back({1'b1, 8'h14});
        dq[2].push_back({1'b0, 8'h22}); dq[2].push_back({1'b1, 8'h23});
        run(0, 1'b0);
`ifdef UART_ARB_TAG_EN
        chk("ptr0_gives_req2", 32'(wr_log[0]), 32'hA2);
`else
        chk("ptr0_gives_req2", 32'(wr_log[0]), 32'h22);
`endif

        // Full held high for five cycles mid-message.
        do_reset();
        for (int b = 0; b < 4; b++) dq[1].push_back({b == 3, 8'(8'h31 + b)});
        run(1, 1'b0);

        // MAX_LEN split: requester 3 streams 10 bytes while requester 1 waits.
        do_reset();
        dq[2].push_back({1'b1, 8'h40});
        run(0, 1'b0);
        for (int b = 0; b < 10; b++) dq[3].push_back({b == 9, 8'(8'h50 + b)});
        dq[1].push_back({1'b0, 8'h60}); dq[1].push_back({1'b1, 8'h61});
        run(0, 1'b0);
`ifdef UART_ARB_TAG_EN
        chk("maxlen_interleave", 32'(wr_log[6]), 32'h60);
`else
        chk("maxlen_interleave", 32'(wr_log[4]), 32'h60);
`endif

        // Reset mid-message after two of five bytes.
        do_reset();
        cnt = 0;
        guard = 0;
        while (cnt < 2 && guard < 50) begin
            @(negedge clk);
            drive(4'b0010, 32'(8'h70 + cnt) << 8, 4'b0000, 1'b0);
            #1;
            if (bus.o_req_ready[1]) cnt++;
            guard++;
        end
        chk("pre_reset_progress", 32'(cnt), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0011, 32'h0000_7101, 4'b0000, 1'b0);
        #1;
        chk("after_reset_grant", 32'(bus.o_grant), 32'd0);
        chk("after_reset_write", 32'(bus.o_write), 32'd0);
        chk("after_reset_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        #1;
        chk("fresh_grant_req0", 32'(bus.o_grant), 32'b0001);

        // Randomized traffic with random full and valid gaps from the owner.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(1) == 0) do_reset();
            for (int k = 0; k < N; k++) begin
                nm = $urandom_range(2);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++) dq[k].push_back({b == len - 1, 8'($urandom)});
                end
            end
            run(2, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
